// File: rtl/csa_pkg.sv
// Shared constants and result record for the pipelined carry-select adder.
// Optional overflow output is enabled by defining CSA_PIPE_OVF_EN.
package csa_pkg;

    localparam int CSA_WIDTH_DEF = 16;
    localparam int CSA_BLK_DEF   = 4;

    typedef struct packed {
        logic [CSA_WIDTH_DEF-1:0] sum;
        logic                     cout;
        logic                     ovf;
    } csa_res_t;

endpackage

// File: rtl/csa_pipe_blk.sv
// One carry-select block: sums for carry-in 0 and 1, picked by the real carry.
// Used by csa_pipe for every block above block 0 (CSA_PIPE_OVF_EN unrelated).
module csa_blk
    import csa_pkg::*;
#(
    parameter int BLK = CSA_BLK_DEF
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co
);

    logic [BLK:0] r0;
    logic [BLK:0] r1;

    assign r0 = {1'b0, a} + {1'b0, b};
    assign r1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

    assign {co, s} = ci ? r1 : r0;

endmodule

// File: rtl/csa_pipe.sv
// Two-stage carry-select adder with valid/ready handshake on both sides.
// Define CSA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module csa_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH_DEF,
    parameter int BLK   = CSA_BLK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int HW = WIDTH / 2;
    localparam int NH = HW / BLK;

    if ((WIDTH % (2 * BLK)) != 0 || WIDTH < 2 * BLK) begin : g_bad_cfg
        $error("csa_pipe: WIDTH must be a non-zero multiple of 2*BLK");
    end

    logic          s1_valid;
    logic [HW-1:0] s1_lo;
    logic          s1_c;
    logic [HW-1:0] s1_a_hi;
    logic [HW-1:0] s1_b_hi;
    logic          s2_valid;

    logic          s1_adv;
    logic          acc;

    logic [HW-1:0] lo_sum;
    logic          lo_co;
    logic [HW-1:0] hi_sum;
    logic          hi_co;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign acc       = in_valid && in_ready;
    assign out_valid = s2_valid;

    // Low half: block 0 ripples from cin, the rest select on the chained carry.
    for (genvar i = 0; i < NH; i++) begin : g_lo
        logic ci;
        logic co;
        if (i == 0) begin : g_rip
            assign ci = cin;
            assign {co, lo_sum[BLK-1:0]} =
                {1'b0, op1[BLK-1:0]} + {1'b0, op2[BLK-1:0]} +
                {{BLK{1'b0}}, ci};
        end else begin : g_sel
            assign ci = g_lo[i-1].co;
            csa_blk #(
                .BLK (BLK)
            ) u_blk (
                .a  (op1[i*BLK +: BLK]),
                .b  (op2[i*BLK +: BLK]),
                .ci (ci),
                .s  (lo_sum[i*BLK +: BLK]),
                .co (co)
            );
        end
    end

    assign lo_co = g_lo[NH-1].co;

    // High half works from the registered operands and the registered carry.
    for (genvar j = 0; j < NH; j++) begin : g_hi
        logic ci;
        logic co;
        if (j == 0) begin : g_first
            assign ci = s1_c;
        end else begin : g_next
            assign ci = g_hi[j-1].co;
        end
        csa_blk #(
            .BLK (BLK)
        ) u_blk (
            .a  (s1_a_hi[j*BLK +: BLK]),
            .b  (s1_b_hi[j*BLK +: BLK]),
            .ci (ci),
            .s  (hi_sum[j*BLK +: BLK]),
            .co (co)
        );
    end

    assign hi_co = g_hi[NH-1].co;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c     <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (acc) begin
                s1_lo   <= lo_sum;
                s1_c    <= lo_co;
                s1_a_hi <= op1[WIDTH-1:HW];
                s1_b_hi <= op2[WIDTH-1:HW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv && s1_valid) begin
                sum  <= {hi_sum, s1_lo};
                cout <= hi_co;
            end
        end
    end

`ifdef CSA_PIPE_OVF_EN
    logic ovf_nxt;

    // Like-signed operands producing an opposite-signed sum.
    assign ovf_nxt = (s1_a_hi[HW-1] == s1_b_hi[HW-1]) &&
                     (hi_sum[HW-1] != s1_a_hi[HW-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (s1_adv && s1_valid) begin
            ovf <= ovf_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// Self-checking bench for csa_pipe: vector table, handshake sequences, random run.
// Honours CSA_PIPE_OVF_EN for the ovf port and its checks.
module tb_csa_pipe;
    import csa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef CSA_PIPE_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_pipe #(
        .WIDTH (16),
        .BLK   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        csa_res_t    exp;
    } vec_t;

    vec_t     tbl [12];
    csa_res_t q [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input csa_res_t e);
        chk({nm, ".sum"}, 32'(sum), 32'(e.sum));
        chk({nm, ".cout"}, 32'(cout), 32'(e.cout));
`ifdef CSA_PIPE_OVF_EN
        chk({nm, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    endtask

    // Reference: plain wide addition plus the signed-overflow rule.
    function automatic csa_res_t model(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic ci);
        logic [16:0] t;
        csa_res_t    r;
        t      = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic ci, input logic [15:0] s,
                                input logic co, input logic ov);
        vec_t v;
        v.a        = a;
        v.b        = b;
        v.ci       = ci;
        v.exp.sum  = s;
        v.exp.cout = co;
        v.exp.ovf  = ov;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        in_valid = v;
        op1      = a;
        op2      = b;
        cin      = c;
        #1;
    endtask

    csa_res_t    e;
    logic        stall_prev;
    logic [15:0] held_sum;
    logic        held_cout;

    initial begin
        tbl[0]  = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        tbl[1]  = mk(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
        tbl[2]  = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        tbl[3]  = mk(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        tbl[4]  = mk(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        tbl[5]  = mk(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        tbl[6]  = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        tbl[7]  = mk(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        tbl[8]  = mk(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        tbl[9]  = mk(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
        tbl[10] = mk(16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b0);
        tbl[11] = mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        step();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
`ifdef CSA_PIPE_OVF_EN
        chk("rst.ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Single transactions: result must show exactly two edges after accept.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci);
            chk("vec.in_ready", 32'(in_ready), 32'd1);
            step();
            drive(1'b0, 16'h0, 16'h0, 1'b0);
            chk("vec.lat1.out_valid", 32'(out_valid), 32'd0);
            step();
            chk("vec.out_valid", 32'(out_valid), 32'd1);
            chk_res($sformatf("vec%0d", i), tbl[i].exp);
        end
        step();
        chk("vec.idle", 32'(out_valid), 32'd0);

        // Back-to-back accepts give one result per cycle.
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                drive(1'b1, 16'(i + 1), 16'(i + 1), 1'b0);
                chk("b2b.in_ready", 32'(in_ready), 32'd1);
            end else begin
                drive(1'b0, 16'h0, 16'h0, 1'b0);
            end
            step();
            if (i >= 1 && i <= 3) begin
                chk("b2b.out_valid", 32'(out_valid), 32'd1);
                chk("b2b.sum", 32'(sum), 32'(2 * i));
            end else if (i == 4) begin
                chk("b2b.end", 32'(out_valid), 32'd0);
            end
        end

        // Downstream stall with three operations offered.
        out_ready = 1'b0;
        drive(1'b1, 16'd1, 16'd1, 1'b0);
        chk("stall.acc1", 32'(in_ready), 32'd1);
        step();
        drive(1'b1, 16'd2, 16'd2, 1'b0);
        chk("stall.acc2", 32'(in_ready), 32'd1);
        step();
        chk("stall.v1", 32'(out_valid), 32'd1);
        chk("stall.s1", 32'(sum), 32'd2);
        drive(1'b1, 16'd3, 16'd3, 1'b0);
        chk("stall.full", 32'(in_ready), 32'd0);
        step();
        chk("stall.hold_v", 32'(out_valid), 32'd1);
        chk("stall.hold_s", 32'(sum), 32'd2);
        chk("stall.full2", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("stall.release", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("stall.s2", 32'(sum), 32'd4);
        step();
        chk("stall.s3v", 32'(out_valid), 32'd1);
        chk("stall.s3", 32'(sum), 32'd6);
        step();
        chk("stall.empty", 32'(out_valid), 32'd0);

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        drive(1'b1, 16'd7, 16'd7, 1'b0);
        step();
        drive(1'b1, 16'd8, 16'd8, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.sum", 32'(sum), 32'd0);
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst.quiet", 32'(out_valid), 32'd0);
        end
        drive(1'b1, 16'd5, 16'd5, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("mrst.lat1", 32'(out_valid), 32'd0);
        step();
        chk("mrst.new_v", 32'(out_valid), 32'd1);
        chk("mrst.new_s", 32'(sum), 32'd10);
        step();

        // Random traffic against an in-order queue model.
        stall_prev = 1'b0;
        held_sum   = '0;
        held_cout  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom % 4) != 0;
            drive(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                  1'($urandom));
            if (stall_prev) begin
                chk("rand.hold_v", 32'(out_valid), 32'd1);
                chk("rand.hold_s", 32'(sum), 32'(held_sum));
                chk("rand.hold_c", 32'(cout), 32'(held_cout));
            end
            if (out_ready) begin
                chk("rand.in_ready", 32'(in_ready), 32'd1);
            end
            if (q.size() == 2 && out_valid && !out_ready) begin
                chk("rand.full", 32'(in_ready), 32'd0);
            end
            if (out_valid && q.size() == 0) begin
                chk("rand.spurious", 32'(out_valid), 32'd0);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                chk_res("rand", e);
            end
            if (in_valid && in_ready) begin
                q.push_back(model(op1, op2, cin));
            end
            stall_prev = out_valid && !out_ready;
            held_sum   = sum;
            held_cout  = cout;
            step();
        end

        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (out_valid && q.size() == 0) begin
                chk("drain.spurious", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                e = q.pop_front();
                chk_res("drain", e);
            end
            step();
        end
        chk("drain.left", 32'(q.size()), 32'd0);
        chk("drain.idle", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_pipe.md
CSA_PIPE -- requirements
Module: csa_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter BLK, default 4, carry-select block width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operands and carry-in presented this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 op1, op2  input  WIDTH  addend operands, unsigned; two's-complement when overflow is compiled in.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  sum, cout (and ovf) valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 sum  output  WIDTH  op1+op2+cin modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The adder SHALL be a carry-select adder of WIDTH/BLK blocks: block 0 rippled from cin; every other block computed for carry 0 and carry 1, with the block carry-in selecting the result.
REQ-014 Stage 1 SHALL compute the low WIDTH/2 bits and their carry and register them with op1/op2 high halves and s1_valid.
REQ-015 Stage 2 SHALL compute the high WIDTH/2 bits selected by the registered carry and register sum, cout and s2_valid; out_valid equals s2_valid.
REQ-016 Accept SHALL occur on cycles with in_valid=1 and in_ready=1; the result SHALL appear with out_valid=1 exactly 2 cycles after accept when not stalled.
REQ-017 s1_adv = !s2_valid || out_ready; in_ready = !s1_valid || s1_adv (combinational from out_ready).
REQ-018 Sustained throughput SHALL be one result per cycle with out_ready held 1.
REQ-019 With out_valid=1 and out_ready=0, sum/cout/ovf SHALL hold stable, stage 1 SHALL hold if occupied, and in_ready SHALL drop once stage 1 is occupied.
REQ-020 Stage 1 SHALL load a bubble (s1_valid=0) when it advances without an accept; stage 2 likewise when it advances with s1_valid=0.
REQ-021 Simultaneous accept and result drain SHALL lose or duplicate no transaction; results SHALL leave in accept order.
REQ-022 Data registers SHALL not change when their stage does not advance.

Reset
REQ-023 On clk edge with rst_n=0: s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0, ovf=0.
REQ-024 in_ready SHALL be 1 in the first cycle after reset release.
REQ-025 Reset mid-operation SHALL discard all in-flight transactions; none SHALL emerge afterwards.

Configuration
REQ-026 Macro CSA_PIPE_OVF_EN defined: output ovf (1 bit) SHALL exist, asserted when op1 and op2 have equal MSBs differing from sum MSB, registered alongside sum.
REQ-027 Macro CSA_PIPE_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package csa_pkg SHALL hold CSA_WIDTH_DEF=16 and CSA_BLK_DEF=4 constants and a result record type {sum, cout, ovf}.
REQ-029 Sub-module csa_blk (BLK-bit dual-carry block with select mux) SHALL be instantiated per block above block 0.
REQ-030 WIDTH SHALL be an even multiple of BLK (WIDTH % (2*BLK) == 0); otherwise elaboration SHALL fail.

Verification
REQ-031 WIDTH=16: op1=0xFFFF, op2=0x0001, cin=0 -> 2 cycles later sum=0x0000, cout=1, out_valid=1.
REQ-032 op1=0x00FF, op2=0x0000, cin=1 -> sum=0x0100, cout=0 (carry crosses block and half boundary).
REQ-033 CSA_PIPE_OVF_EN: op1=0x7FFF, op2=0x0001, cin=0 -> sum=0x8000, ovf=1; op1=0x8000, op2=0xFFFF -> sum=0x7FFF, cout=1, ovf=1.
REQ-034 Back-to-back accepts 1+1, 2+2, 3+3 with out_ready=1 -> sums 2, 4, 6 on consecutive cycles.
REQ-035 out_ready=0 for 3 cycles with 3 ops offered -> 2 accepted, in_ready=0, outputs held; release -> 2, 4 in order, then third accepted.
REQ-036 rst_n=0 one cycle with 2 ops in flight -> out_valid=0 thereafter until a new accept plus 2 cycles.
